// File: rtl/cnoc_indication_deframer.sv
// cnoc_indication_deframer
//
// Sits behind the CNoC indication message FIFO.
// - Pops 32-bit message words and parses each header.
// - Checks the header's length and method id.
// - Streams payload words to the host through a single registered
//   valid/ready output stage.
// - Malformed messages are consumed and dropped so the FIFO never stalls.
//
// Header word: [23:16] method id ([31:24] ignored),
//              [15:0]  total word count W, including the header.
//
// Ports
//   CLK, RST_N    clock; synchronous active-low reset
//   in_first      head word of the indication FIFO
//   in_notEmpty   FIFO holds a word
//   in_deq        pop strobe (only asserted with in_notEmpty)
//   out_valid     output beat valid
//   out_ready     consumer accepts the beat
//   out_data      payload word (0 for a zero-length message)
//   out_method    method id of the message the beat belongs to
//   out_first     first beat of the message
//   out_last      last beat of the message
//   out_nodata    beat carries no payload (header-only message)
//   err_len       one-cycle pulse: illegal header length
//   err_method    one-cycle pulse: method id out of range
//
// Optional build macro CNOC_DEFRAMER_STATS_EN adds two counters:
//   msg_count     [31:0] delivered messages (last-beat handshakes); wraps
//   drop_count    [15:0] error pulses; saturates

module cnoc_indication_deframer #(
    parameter int NUM_METHODS = 2,
    parameter int MAX_WORDS   = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] in_first,
    input  logic        in_notEmpty,
    output logic        in_deq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_method,
    output logic        out_first,
    output logic        out_last,
    output logic        out_nodata,
    output logic        err_len,
    output logic        err_method
`ifdef CNOC_DEFRAMER_STATS_EN
    ,
    output logic [31:0] msg_count,
    output logic [15:0] drop_count
`endif
);

    typedef enum logic [1:0] {HDR, PAY, DROP} stateT;

    stateT       state, stateNext;
    logic [15:0] remaining, remainingNext;
    logic        firstPend, firstPendNext;
    logic [7:0]  curMethod, curMethodNext;
    logic        deq, load, loadNodata;
    logic        errLenNext, errMethodNext;

    logic        slotFree;
    logic [15:0] hdrWords, hdrPay;
    logic [7:0]  hdrMethod;
    logic        lenBad, methodBad;

    // The output register can take a new beat when empty or draining now.
    assign slotFree  = !out_valid || out_ready;
    assign hdrWords  = in_first[15:0];
    assign hdrPay    = hdrWords - 16'd1;
    assign hdrMethod = in_first[23:16];
    // hdrPay is only meaningful when hdrWords != 0; the OR short-circuits
    // the wrapped value in that case.
    assign lenBad    = (hdrWords == 16'd0) || (hdrPay > 16'(MAX_WORDS));
    assign methodBad = ({24'd0, hdrMethod} >= 32'(NUM_METHODS));

    // Nothing is popped while reset is held, so the FIFO keeps its words
    // for the header parse that follows reset.
    assign in_deq = deq && RST_N;

    // NOTE: every signal gets a default before the case statement so no
    // path leaves one unassigned; otherwise a latch is inferred.
    always_comb begin
        stateNext     = state;
        remainingNext = remaining;
        firstPendNext = firstPend;
        curMethodNext = curMethod;
        deq           = 1'b0;
        load          = 1'b0;
        loadNodata    = 1'b0;
        errLenNext    = 1'b0;
        errMethodNext = 1'b0;

        case (state)
            HDR: begin
                if (in_notEmpty) begin
                    if (lenBad) begin
                        // Length errors outrank method errors.
                        deq        = 1'b1;
                        errLenNext = 1'b1;
                        if (hdrWords != 16'd0) begin
                            remainingNext = hdrPay;
                            stateNext     = DROP;
                        end
                    end else if (methodBad) begin
                        deq           = 1'b1;
                        errMethodNext = 1'b1;
                        if (hdrPay != 16'd0) begin
                            remainingNext = hdrPay;
                            stateNext     = DROP;
                        end
                    end else if (hdrPay == 16'd0) begin
                        // Header-only message becomes a single no-data
                        // beat, so it must wait for a free output slot.
                        if (slotFree) begin
                            deq        = 1'b1;
                            load       = 1'b1;
                            loadNodata = 1'b1;
                        end
                    end else begin
                        deq           = 1'b1;
                        curMethodNext = hdrMethod;
                        remainingNext = hdrPay;
                        firstPendNext = 1'b1;
                        stateNext     = PAY;
                    end
                end
            end

            PAY: begin
                if (in_notEmpty && slotFree) begin
                    deq           = 1'b1;
                    load          = 1'b1;
                    remainingNext = remaining - 16'd1;
                    firstPendNext = 1'b0;
                    if (remaining == 16'd1) stateNext = HDR;
                end
            end

            DROP: begin
                // Drained regardless of the consumer.
                if (in_notEmpty) begin
                    deq           = 1'b1;
                    remainingNext = remaining - 16'd1;
                    if (remaining == 16'd1) stateNext = HDR;
                end
            end

            default: stateNext = HDR;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values, independent of block order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= HDR;
            remaining  <= 16'd0;
            firstPend  <= 1'b0;
            curMethod  <= 8'd0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_method <= 8'd0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_nodata <= 1'b0;
            err_len    <= 1'b0;
            err_method <= 1'b0;
        end else begin
            state      <= stateNext;
            remaining  <= remainingNext;
            firstPend  <= firstPendNext;
            curMethod  <= curMethodNext;
            err_len    <= errLenNext;
            err_method <= errMethodNext;
            if (load) begin
                // A load may coincide with the drain of the previous beat.
                out_valid  <= 1'b1;
                out_data   <= loadNodata ? 32'd0 : in_first;
                out_method <= loadNodata ? hdrMethod : curMethod;
                out_first  <= loadNodata ? 1'b1 : firstPend;
                out_last   <= loadNodata ? 1'b1 : (remaining == 16'd1);
                out_nodata <= loadNodata;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef CNOC_DEFRAMER_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            msg_count  <= 32'd0;
            drop_count <= 16'd0;
        end else begin
            if (out_valid && out_ready && out_last)
                msg_count <= msg_count + 32'd1;
            if ((err_len || err_method) && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnoc_indication_deframer.sv
// Directed testbench for cnoc_indication_deframer.
// A queue stands in for the upstream indication FIFO; accepted output
// beats are collected and compared with hand-computed expectations.

module tb_cnoc_indication_deframer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] in_first;
    logic        in_notEmpty;
    logic        in_deq;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_method;
    logic        out_first, out_last, out_nodata;
    logic        err_len, err_method;

    always #5 CLK = ~CLK;

    cnoc_indication_deframer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_first    (in_first),
        .in_notEmpty (in_notEmpty),
        .in_deq      (in_deq),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_method  (out_method),
        .out_first   (out_first),
        .out_last    (out_last),
        .out_nodata  (out_nodata),
        .err_len     (err_len),
        .err_method  (err_method)
    );

    typedef struct packed {
        logic [7:0]  method;
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        nodata;
    } Beat;

    logic [31:0] fifo[$];
    logic        readyQ[$];
    logic        readyDef;
    Beat         gotQ[$];
    Beat         expQ[$];
    int          nChecks, nFail;
    int          popCnt, errLenCnt, errMethCnt;
    int          basePop, baseLen, baseMeth;
    logic        prevHeld;
    Beat         prevBeat;
    logic        noDeqWhenHeld;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic Beat mk(logic [7:0] m, logic [31:0] d, logic f, logic l, logic n);
        Beat b;
        b = {m, d, f, l, n};
        return b;
    endfunction

    function automatic Beat curBeat();
        Beat b;
        b = {out_method, out_data, out_first, out_last, out_nodata};
        return b;
    endfunction

    task automatic applyInputs();
        out_ready   = (readyQ.size() != 0) ? readyQ.pop_front() : readyDef;
        in_notEmpty = (fifo.size() != 0);
        in_first    = (fifo.size() != 0) ? fifo[0] : 32'd0;
    endtask

    task automatic refresh();
        applyInputs();
        #1;
    endtask

    // Observe the current cycle, account for pops/beats/errors, then
    // advance one clock and present the next inputs.
    task automatic cycle();
        check("deq_without_data", {31'd0, in_deq & ~in_notEmpty}, 0);
        if (prevHeld) begin
            check("stall_valid", {63'd0, out_valid}, 1);
            check("stall_fields", curBeat(), prevBeat);
        end
        if (noDeqWhenHeld && out_valid && !out_ready)
            check("deq_while_held", {63'd0, in_deq}, 0);
        errLenCnt  += int'(err_len);
        errMethCnt += int'(err_method);
        if (out_valid && out_ready && RST_N) gotQ.push_back(curBeat());
        prevHeld = out_valid && !out_ready && RST_N;
        prevBeat = curBeat();
        if (in_deq) begin
            void'(fifo.pop_front());
            popCnt++;
        end
        @(posedge CLK);
        #1;
        applyInputs();
        @(negedge CLK);
    endtask

    task automatic runIdle(input string tag);
        int n = 0;
        while ((fifo.size() != 0 || out_valid) && n < 300) begin
            cycle();
            n++;
        end
        cycle();
        check({tag, "_drained"}, fifo.size(), 0);
    endtask

    task automatic checkBeats(input string tag);
        check({tag, "_beats"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), gotQ[i], expQ[i]);
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic markBase();
        basePop  = popCnt;
        baseLen  = errLenCnt;
        baseMeth = errMethCnt;
    endtask

    task automatic checkCounts(input string tag, input int pops, input int lens, input int meths);
        check({tag, "_pops"},    popCnt - basePop, pops);
        check({tag, "_errlen"},  errLenCnt - baseLen, lens);
        check({tag, "_errmeth"}, errMethCnt - baseMeth, meths);
    endtask

    task automatic expectOut(input string tag, input logic v, input Beat b, input logic d);
        check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        check({tag, "_deq"},   {63'd0, in_deq},    {63'd0, d});
        if (v) check({tag, "_beat"}, curBeat(), b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nChecks = 0; nFail = 0; popCnt = 0; errLenCnt = 0; errMethCnt = 0;
        prevHeld = 1'b0; noDeqWhenHeld = 1'b0; readyDef = 1'b1;
        RST_N = 1'b0; in_first = 32'd0; in_notEmpty = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge CLK);
        refresh();
        repeat (3) cycle();
        check("reset_outputs", {out_valid, out_data, out_method, out_first, out_last,
                                out_nodata, err_len, err_method, in_deq}, 0);
        RST_N = 1'b1;
        refresh();
        cycle();

        // Two-word message, each beat one cycle after its pop
        markBase();
        fifo = '{32'h0001_0003, 32'h11, 32'h22};
        refresh();
        expectOut("t1_c0", 1'b0, mk(0, 0, 0, 0, 0), 1'b1); cycle();
        expectOut("t1_c1", 1'b0, mk(0, 0, 0, 0, 0), 1'b1); cycle();
        expectOut("t1_c2", 1'b1, mk(8'd1, 32'h11, 1, 0, 0), 1'b1); cycle();
        expectOut("t1_c3", 1'b1, mk(8'd1, 32'h22, 0, 1, 0), 1'b0); cycle();
        check("t1_c4_valid", {63'd0, out_valid}, 0);
        checkCounts("t1", 3, 0, 0);
        gotQ.delete();

        // Header-only message
        markBase();
        fifo = '{32'h0000_0001};
        refresh();
        expectOut("t2_c0", 1'b0, mk(0, 0, 0, 0, 0), 1'b1); cycle();
        expectOut("t2_c1", 1'b1, mk(8'd0, 32'd0, 1, 1, 1), 1'b0); cycle();
        check("t2_c2_valid", {63'd0, out_valid}, 0);
        checkCounts("t2", 1, 0, 0);
        gotQ.delete();

        // Bad method, dropped with consumer stalled
        markBase();
        readyDef = 1'b0;
        fifo = '{32'h0005_0003, 32'h1, 32'h2};
        refresh();
        for (int i = 0; i < 3; i++) begin
            expectOut($sformatf("t3_drop%0d", i), 1'b0, mk(0, 0, 0, 0, 0), 1'b1);
            cycle();
        end
        check("t3_after_valid", {63'd0, out_valid}, 0);
        cycle();
        checkCounts("t3", 3, 0, 1);
        markBase();
        readyDef = 1'b1;
        fifo = '{32'h0000_0002, 32'hAB};
        refresh();
        runIdle("t3b");
        expQ = '{mk(8'd0, 32'hAB, 1, 1, 0)};
        checkBeats("t3b");
        checkCounts("t3b", 2, 0, 0);

        // Zero-length header
        markBase();
        fifo = '{32'h0000_0000};
        refresh();
        runIdle("t4");
        checkBeats("t4");
        checkCounts("t4", 1, 1, 0);

        // Both length and method illegal: only err_len
        markBase();
        fifo = '{32'h0003_0000};
        refresh();
        runIdle("t4b");
        checkBeats("t4b");
        checkCounts("t4b", 1, 1, 0);

        // Oversize message (P=19) dropped, then a header-only message
        markBase();
        fifo = '{32'h0000_0014};
        for (int i = 0; i < 19; i++) fifo.push_back(32'h0000_0013);
        fifo.push_back(32'h0001_0001);
        refresh();
        runIdle("t5");
        expQ = '{mk(8'd1, 32'd0, 1, 1, 1)};
        checkBeats("t5");
        checkCounts("t5", 21, 1, 0);

        // Largest legal message (P=16) with ignored top header byte
        markBase();
        fifo = '{32'hFF01_0011};
        for (int i = 0; i < 16; i++) begin
            fifo.push_back(32'h100 + i);
            expQ.push_back(mk(8'd1, 32'h100 + i, i == 0, i == 15, 0));
        end
        refresh();
        runIdle("t5b");
        checkBeats("t5b");
        checkCounts("t5b", 17, 0, 0);

        // Back-pressure pattern on a 4-word message
        markBase();
        readyQ = '{1, 0, 0, 1, 1, 0, 1};
        noDeqWhenHeld = 1'b1;
        fifo = '{32'h0000_0005, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        refresh();
        runIdle("t6");
        noDeqWhenHeld = 1'b0;
        expQ = '{mk(0, 32'hA1, 1, 0, 0), mk(0, 32'hA2, 0, 0, 0),
                 mk(0, 32'hA3, 0, 0, 0), mk(0, 32'hA4, 0, 1, 0)};
        checkBeats("t6");
        checkCounts("t6", 5, 0, 0);

        // Reset after one of three payload words
        markBase();
        fifo = '{32'h0001_0004, 32'hB1, 32'h0000_0001, 32'h0001_0001};
        refresh();
        cycle();
        cycle();
        check("t7_beat_before_reset", curBeat(), mk(8'd1, 32'hB1, 1, 0, 0));
        RST_N = 1'b0;
        #1;
        check("t7_deq_in_reset", {63'd0, in_deq}, 0);
        cycle();
        check("t7_reset_outputs", {out_valid, out_data, out_method, out_first, out_last,
                                   out_nodata, err_len, err_method, in_deq}, 0);
        gotQ.delete();
        RST_N = 1'b1;
        refresh();
        runIdle("t7");
        expQ = '{mk(8'd0, 32'd0, 1, 1, 1), mk(8'd1, 32'd0, 1, 1, 1)};
        checkBeats("t7");
        checkCounts("t7", 4, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/cnoc_indication_deframer.md
Name: cnoc_indication_deframer

Overview:
- Sits directly downstream of the CNoC top's indication message port (`indications_0_message_first` / `_deq` / `_notEmpty`).
- Pops 32-bit CNoC message words, parses each header and checks it.
- Delivers payload words tagged with method id and first/last markers to a host-side valid/ready stream.
- Malformed or out-of-range messages are consumed and dropped so the indication FIFO never stalls.

Parameters:
- NUM_METHODS, 2, number of valid indication method ids (0..NUM_METHODS-1).
- MAX_WORDS, 16, maximum accepted payload words per message (excludes header).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- in_first  in  32  head word of indication message FIFO
- in_notEmpty  in  1  FIFO has a word
- in_deq  out  1  pop strobe; asserted only when in_notEmpty=1
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  32  payload word
- out_method  out  8  method id of the current message
- out_first  out  1  first beat of message
- out_last  out  1  last beat of message
- out_nodata  out  1  beat carries no payload (zero-length message)
- err_len  out  1  one-cycle pulse: header length illegal
- err_method  out  1  one-cycle pulse: method id >= NUM_METHODS

Behaviour:
- Header word format:
  - [31:16] method number; only [23:16] is significant, [31:24] is ignored.
  - [15:0] W = total words including the header.
  - Payload count P = W-1.
- slot_free = !out_valid || out_ready.
- State HDR (reset state), when in_notEmpty:
  - W==0: pop the header and pulse err_len. Stay in HDR; nothing is emitted. slot_free is not required.
  - P>MAX_WORDS: pop, pulse err_len, load remaining=P, go to DROP. slot_free is not required.
  - method>=NUM_METHODS: pop, pulse err_method, load remaining=P, go to DROP (or stay in HDR if P==0).
  - W==1, method legal, slot_free:
    - Pop; emit one beat next cycle with out_data=0 and out_first=out_last=out_nodata=1.
    - Stay in HDR.
  - P>=1, legal:
    - Pop, latch method, remaining=P, set first_pend=1, go to PAY.
    - The header is not emitted.
  - When both length and method are illegal, err_len takes priority and only err_len pulses.
- State PAY:
  - in_deq = in_notEmpty && slot_free.
  - Each pop loads the output register: out_data=in_first, out_first=first_pend, out_last=(remaining==1), out_nodata=0.
  - Each pop decrements remaining and clears first_pend.
  - Popping with remaining==1 returns to HDR.
- State DROP:
  - in_deq = in_notEmpty, independent of out_ready.
  - Each pop decrements remaining; remaining==1 on pop returns to HDR.
- Output register:
  - Loaded the cycle after a pop; in_first popped in cycle N appears on out_data in cycle N+1.
  - out_valid clears on out_ready when no new load occurs that cycle.
  - Load and drain in the same cycle are allowed, giving one word/cycle sustained throughput.
  - Fields hold stable while out_valid && !out_ready.
- Back-to-back messages: the next header may be popped the cycle after the last payload pop.
- remaining is 16 bits and never wraps; underflow is impossible by construction.
- Reset:
  - State=HDR, remaining=0, first_pend=0.
  - out_valid=0, out_data=0, out_method=0, out_first=out_last=out_nodata=0.
  - err_*=0, in_deq=0.
- Reset mid-message:
  - The partial message is abandoned; the upstream FIFO is not flushed.
  - The next popped word is parsed as a header. The system resets both sides together.

Optional Feature:
- Macro CNOC_DEFRAMER_STATS_EN.
- When defined, adds output ports:
  - msg_count[31:0]: increments on each delivered out_last beat acceptance (out_valid && out_ready && out_last); wraps.
  - drop_count[15:0]: increments on each err_len or err_method pulse; saturates at 16'hFFFF.
  - Both counters reset to 0.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Header 32'h0001_0003 then payload 32'h11, 32'h22, out_ready=1:
  - Two beats, method=1, data 11 (first=1, last=0) then 22 (first=0, last=1).
  - Each beat appears 1 cycle after its pop.
- Header 32'h0000_0001 -> one beat: method=0, data=0, first=last=nodata=1.
- Header 32'h0005_0003 plus 2 words with out_ready=0 throughout:
  - err_method pulses once; all 3 words are popped in 3 cycles; out_valid stays 0.
  - The following header 32'h0000_0002 + 32'hAB is delivered normally.
- Header 32'h0000_0000 -> err_len pulse, one pop, no beat.
- Header 32'h0000_0014 (P=19 > 16) -> err_len, 19 payload words dropped.
- 4-word payload with out_ready toggling 1,0,0,1,1,0,1:
  - No beat is lost or duplicated; fields are stable while stalled; in_deq is never asserted while the output is held.
- Reset asserted after 1 of 3 payload words -> all outputs 0 the next cycle; the next word is parsed as a header.
